// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants and fetch buffer entry type for the instruction fetch unit
package ifu_pkg;

    localparam int          PC_W           = 32;
    localparam logic [31:0] DEFAULT_RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP            = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     data;
        logic            err;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_buf.sv
// rtl/ifu_buf.sv - in-order ring buffer of fetch entries with alloc/fill/pop/flush
module ifu_buf
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    input  logic [PC_W-1:0] alloc_pc,
    input  logic            fill,
    input  logic [31:0]     fill_data,
    input  logic            fill_err,
    input  logic            pop,
    input  logic            flush,
    output fetch_entry_t    head,
    output logic [CW-1:0]   occ
);

    fetch_entry_t  entries_q [DEPTH];
    fetch_entry_t  entries_d [DEPTH];
    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0] fill_ptr_q, fill_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;

    assign head = entries_q[rd_ptr_q];
    assign occ  = occ_q;

    // Entry and pointer updates; a flush drops everything, otherwise pop/alloc/fill touch distinct slots.
    always_comb begin
        entries_d   = entries_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
        end else begin
            if (pop) begin
                entries_d[rd_ptr_q].filled = 1'b0;
                rd_ptr_d                   = rd_ptr_q + 1'b1;
            end
            if (alloc) begin
                entries_d[alloc_ptr_q].pc     = alloc_pc;
                entries_d[alloc_ptr_q].data   = '0;
                entries_d[alloc_ptr_q].err    = 1'b0;
                entries_d[alloc_ptr_q].filled = 1'b0;
                alloc_ptr_d                   = alloc_ptr_q + 1'b1;
            end
            if (fill) begin
                entries_d[fill_ptr_q].data   = fill_data;
                entries_d[fill_ptr_q].err    = fill_err;
                entries_d[fill_ptr_q].filled = 1'b1;
                fill_ptr_d                   = fill_ptr_q + 1'b1;
            end
            occ_d = occ_q + CW'(alloc) - CW'(pop);
        end
    end

    // Buffer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            entries_q   <= entries_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, request issue, response buffering, redirect discard
module ifu
    import ifu_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RST_PC   = DEFAULT_RST_PC,
    parameter int                  DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [DATA_LEN-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                imem_rsp_err,
    input  logic                redirect_valid,
    input  logic [DATA_LEN-1:0] redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [DATA_LEN-1:0] inst_pc,
    output logic                inst_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]       pending_q, pending_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
    logic                live_q, live_d;
    logic [CW-1:0]       occ;
    fetch_entry_t        head;
    logic                req_fire, out_fire, rsp_drop;

    // live_q keeps the request channel quiet through reset and the cycle after it.
    assign imem_req_valid = live_q && (occ < CW'(DEPTH)) && (pending_q < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_fire       = inst_valid && inst_ready;
    assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);

    assign inst_valid = head.filled;
    assign inst       = inst_valid ? head.data : 32'h0;
    assign inst_pc    = inst_valid ? head.pc : '0;
    assign inst_fault = inst_valid && head.err;

    ifu_buf #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .alloc     (req_fire),
        .alloc_pc  (fetch_pc_q),
        .fill      (imem_rsp_valid && !rsp_drop),
        .fill_data (imem_rsp_data),
        .fill_err  (imem_rsp_err),
        .pop       (out_fire),
        .flush     (redirect_valid),
        .head      (head),
        .occ       (occ)
    );

    // Next PC, outstanding count and discard count; a redirect dooms everything still unreturned.
    always_comb begin
        live_d     = 1'b1;
        fetch_pc_d = fetch_pc_q;
        pending_d  = pending_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~DATA_LEN'(3);
            drop_cnt_d = pending_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + DATA_LEN'(4);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // Fetch control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q     <= 1'b0;
            fetch_pc_q <= RST_PC;
            pending_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            live_q     <= live_d;
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
